// File: rtl/sa_ram_fifo_ctrl_32x544.sv
// ---------------------------------------------------------------------------
// sa_ram_fifo_ctrl_32x544
//
// Valid/ready FIFO controller wrapped around an external single-port-write,
// registered-read-address RAM (sa_ram_rws_32x544). Words pushed by the
// producer are written at wr_ptr. Reads are issued at rd_ptr. The consumer
// sees the RAM output directly, so the presented word is the live content of
// the last read-issued address.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/ready    producer handshake, in_data is the pushed word
//   out_valid/ready   consumer handshake, out_data = ram_dout
//   ram_wa/we/di      RAM write port (address = wr_ptr, data = in_data)
//   ram_ra/re         RAM read port (address = rd_ptr)
//   ram_dout          RAM read data, valid one cycle after ram_re, held
//   ram_pd            RAM power-down bus, always 0
//   count             entries written and not yet popped (incl. presented)
// ---------------------------------------------------------------------------
module sa_ram_fifo_ctrl_32x544 #(
  parameter int DEPTH = 32,   // must equal 2**AW
  parameter int AW    = 5,
  parameter int DW    = 544
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic [31:0]   ram_pd,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          out_valid_q;
  logic [CW-1:0] pend;     // written but not yet read-issued
  logic          push;
  logic          pop;

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    in_ready = 1'b0;
    ram_re   = 1'b0;
    pend     = count_q - CW'(out_valid_q);
    if (!rst) begin
      // Full is decided from registered count only: a pop in the same cycle
      // does not open a slot, so the presented entry is never overwritten.
      in_ready = (count_q < FULL);
      // Issue a read only when the output register is free or being drained;
      // during a stall ram_dout (and so out_data) must hold.
      ram_re   = (pend != '0) && (!out_valid_q || out_ready);
    end
    push = in_valid && in_ready;
    pop  = out_valid_q && out_ready;
  end

  assign ram_we    = push;
  assign ram_wa    = wr_ptr;
  assign ram_di    = in_data;
  assign ram_ra    = rd_ptr;
  assign ram_pd    = '0;
  assign out_data  = ram_dout;
  assign out_valid = out_valid_q;
  assign count     = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the RAM array is deliberately not cleared on reset; out_valid = 0
  // hides stale contents until fresh data has been read out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap mod DEPTH by overflow.
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_ptr + AW'(ram_re);
      // A slot is released on pop, not on read issue.
      count_q     <= count_q + CW'(push) - CW'(pop);
      out_valid_q <= ram_re || (out_valid_q && !out_ready);
    end
  end

endmodule

// File: doc/sa_ram_fifo_ctrl_32x544.md
Name: sa_ram_fifo_ctrl_32x544

Overview:
- Valid/ready FIFO controller that owns one sa_ram_rws_32x544 instance and drives all of its ports.
- Upstream producers push 544-bit words in. The controller issues RAM writes and reads.
- The downstream consumer sees out_data driven directly from the RAM's dout.
- The RAM has a registered read address, so read data appears one cycle after re and holds until the next re. The controller is built around that timing.

Parameters:
- DEPTH, 32, number of RAM entries; must equal 2**AW.
- AW, 5, RAM address width.
- DW, 544, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  DW  write word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  DW  read word; wired directly to ram_dout.
- ram_wa  out  AW  RAM write address (= wr_ptr).
- ram_we  out  1  RAM write enable.
- ram_di  out  DW  RAM write data (= in_data).
- ram_ra  out  AW  RAM read address (= rd_ptr).
- ram_re  out  1  RAM read enable.
- ram_dout  in  DW  RAM read data.
- ram_pd  out  32  RAM power-down bus; tied to 0.
- count  out  AW+1  occupancy: entries written and not yet popped by the consumer, including the one presented.

Behaviour:

State:
- wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], out_valid reg.
- pend = count - out_valid: entries written but not yet read-issued.

Combinational:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count < DEPTH).
- ram_we = push.
- ram_re = (pend != 0) & (!out_valid | out_ready).

Sequential updates:
- wr_ptr += push; rd_ptr += ram_re. Pointers wrap naturally mod DEPTH.
- count += push - pop.
- out_valid <= ram_re | (out_valid & !out_ready).

Slot lifetime:
- A slot is freed only on pop, never on read issue.
- Required because out_data is M[ra_d] live: the presented entry must not be overwritten while out_valid.
- Invariant: push is never allowed when count == DEPTH, so wa never equals the presented address.

Latency and throughput:
- Push at edge N gives pend > 0 in cycle N+1 → ram_re at edge N+1 → out_valid in cycle N+2. Minimum in-to-out latency is 2 cycles.
- There is no write-to-read bypass.
- Sustained 1 word/cycle with out_ready held high once the pipeline is primed.

Stall:
- out_valid & !out_ready gives ram_re = 0, so ram_dout and out_data hold stable.
- Pushes to other slots continue during a stall.

Simultaneous push and pop:
- Allowed at any count < DEPTH.
- At count == DEPTH, in_ready = 0 regardless of pop in the same cycle: a registered-full decision, with no pass-through.

Reset (rst = 1 at an edge):
- wr_ptr = rd_ptr = 0, count = 0, out_valid = 0.
- Combinationally during reset: in_ready and ram_we/ram_re are forced 0.
- RAM contents are not cleared; stale data is never presented because out_valid = 0.
- Reset mid-traffic discards all stored and presented words.

Other rules:
- out_data is X-tolerant when out_valid = 0; checkers must qualify with out_valid.
- ram_pd is constant 0 in all states.

Test Plan:
1. Single push 0xA5.. at cycle 1, out_ready = 1 → out_valid rises in cycle 3 with out_data = 0xA5..; count goes 0→1→0.
2. 32 consecutive pushes with out_ready = 0 → in_ready drops after the 32nd push and count = 32. A 33rd in_valid is not accepted. Pop order is 0..31 values, wr_ptr wraps to 0.
3. Continuous stream of 100 incrementing words with in_valid = out_ready = 1 → after 2-cycle fill, one word per cycle, no gaps or drops, order preserved across pointer wrap.
4. At count = 32 with the head presented, assert in_valid & out_ready in the same cycle → pop occurs and push is rejected that cycle. The push is accepted next cycle; count goes 32→31→32.
5. Hold out_ready = 0 for 10 cycles with out_valid = 1 while pushing 5 words → out_data stays bit-stable and ram_re = 0 throughout; after release, 6 words emerge in order.
6. Assert rst for 1 cycle with count = 12 and out_valid = 1 → next cycle count = 0, out_valid = 0, in_ready = 1. A subsequent push of 0x3C.. appears 2 cycles later with no stale words.
